// File: rtl/axis_arb2_pkt_pkg.sv
// Shared definitions for the two-input AXI-Stream packet arbiter.
//   state_t  : arbiter FSM encoding (IDLE / PASS / DRAIN)
//   PORT0/1  : source port identifiers, also used as m_axis_tid values
//   cnt_bits : width of a counter able to hold 0..max_beats (min 1 bit)
package axis_arb2_pkt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    function automatic int cnt_bits(input int max_beats);
        int b = 1;
        while ((1 << b) < max_beats + 1) b++;
        return b;
    endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// One-deep AXI-Stream output register.
//   in_valid/in_ready/in_data/in_last/in_id : upstream side
//   out_valid/out_ready/out_data/out_last/out_id : registered downstream side
// in_ready is the ready-back term: the slot is free when empty or draining
// this cycle, which gives full throughput while downstream keeps up.
module axis_reg_slice #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    input  logic                  in_id,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  out_id
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_id    <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_last  <= in_last;
            out_id    <= in_id;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_arb2_pkt.sv
// Two-input AXI-Stream packet arbiter with round-robin grant held per packet
// and an optional max-length guard (truncate + drain).
//   clk, rst (async, active-low), en (gates new grants only)
//   s0_axis_* / s1_axis_* : source ports
//   m_axis_*              : registered output, m_axis_tid = source port
//   busy                  : FSM not in IDLE
//   trunc_err             : sticky, set on any truncated packet
//   pkt_cnt0/pkt_cnt1     : wrapping per-port completed-packet counters
module axis_arb2_pkt
    import axis_arb2_pkt_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BEATS  = 256,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic                  s0_axis_tready,
    input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
    input  logic                  s0_axis_tlast,
    input  logic                  s0_axis_tvalid,
    output logic                  s1_axis_tready,
    input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
    input  logic                  s1_axis_tlast,
    input  logic                  s1_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tid,
    output logic                  busy,
    output logic                  trunc_err,
    output logic [CNT_WIDTH-1:0]  pkt_cnt0,
    output logic [CNT_WIDTH-1:0]  pkt_cnt1
);

    localparam int             BW       = cnt_bits(MAX_BEATS);
    localparam logic [BW-1:0]  LAST_IDX = BW'(MAX_BEATS - 1);

    state_t                  state, state_nxt;
    logic                    grant;
    logic                    rr_ptr;
    logic [BW-1:0]           beat_cnt;

    logic                    sel_valid, sel_last;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic                    slice_rdy;
    logic                    src_rdy;
    logic                    accept, pkt_end;
    logic                    trunc_hit, trunc_now;
    logic                    req_any, new_grant;

    // Mux of the granted source; meaningless in IDLE since src_rdy is low.
    assign sel_valid = grant ? s1_axis_tvalid : s0_axis_tvalid;
    assign sel_last  = grant ? s1_axis_tlast  : s0_axis_tlast;
    assign sel_data  = grant ? s1_axis_tdata  : s0_axis_tdata;

    assign accept    = sel_valid && src_rdy;
    assign pkt_end   = accept && sel_last;

    // The beat at index MAX_BEATS-1 without its own tlast closes the
    // forwarded packet early; a genuine tlast there is a normal end.
    assign trunc_hit = (MAX_BEATS != 0) && !sel_last && (beat_cnt == LAST_IDX);
    assign trunc_now = (state == ST_PASS) && accept && trunc_hit;

    assign req_any   = s0_axis_tvalid || s1_axis_tvalid;
    assign new_grant = (state == ST_IDLE) && en && req_any;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (new_grant) state_nxt = ST_PASS;
            ST_PASS: begin
                if (pkt_end)        state_nxt = ST_IDLE;
                else if (trunc_now) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: if (pkt_end) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: source ready for the granted port only
    always_comb begin
        src_rdy = 1'b0;
        case (state)
            ST_PASS:  src_rdy = slice_rdy;
            ST_DRAIN: src_rdy = 1'b1;
            default:  src_rdy = 1'b0;
        endcase
    end

    assign s0_axis_tready = src_rdy && (grant == PORT0);
    assign s1_axis_tready = src_rdy && (grant == PORT1);
    assign busy           = (state != ST_IDLE);

    // Grant, round-robin pointer, beat / packet counters, sticky error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant     <= PORT0;
            rr_ptr    <= PORT0;
            beat_cnt  <= '0;
            pkt_cnt0  <= '0;
            pkt_cnt1  <= '0;
            trunc_err <= 1'b0;
        end else begin
            if (new_grant)
                grant <= (s0_axis_tvalid && s1_axis_tvalid) ? rr_ptr : s1_axis_tvalid;
            if (pkt_end) begin
                rr_ptr   <= ~grant;
                beat_cnt <= '0;
                if (grant == PORT1) pkt_cnt1 <= pkt_cnt1 + 1'b1;
                else                pkt_cnt0 <= pkt_cnt0 + 1'b1;
            end else if ((state == ST_PASS) && accept) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (trunc_now) trunc_err <= 1'b1;
        end
    end

    axis_reg_slice #(.DATA_WIDTH(DATA_WIDTH)) u_out (
        .clk       (clk),
        .rst       (rst),
        .in_valid  ((state == ST_PASS) && sel_valid),
        .in_ready  (slice_rdy),
        .in_data   (sel_data),
        .in_last   (sel_last || trunc_hit),
        .in_id     (grant),
        .out_valid (m_axis_tvalid),
        .out_ready (m_axis_tready),
        .out_data  (m_axis_tdata),
        .out_last  (m_axis_tlast),
        .out_id    (m_axis_tid)
    );

endmodule

// File: doc/axis_arb2_pkt.md
Name: axis_arb2_pkt

Overview:
- Two-input AXI-Stream packet arbiter that shares one downstream datapath between two requesters.
- Round-robin grant; the grant is held for a whole packet (until tlast).
- Optional max-length guard: an overlong packet is truncated on the output and the rest of it is drained from the input.
- Sits in front of the shared stream path so that two frame sources can feed one packet-consuming datapath.

Parameters:
- DATA_WIDTH, 64, tdata width in bits.
- MAX_BEATS, 256, max beats forwarded per packet; 0 disables the guard.
- CNT_WIDTH, 16, width of the per-port packet counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- en  in  1  arbitration enable; low blocks new grants, an in-flight packet still completes
- s0_axis_tready  out  1  port 0 ready
- s0_axis_tdata  in  DATA_WIDTH  port 0 data
- s0_axis_tlast  in  1  port 0 end of packet
- s0_axis_tvalid  in  1  port 0 valid
- s1_axis_tready  out  1  port 1 ready
- s1_axis_tdata  in  DATA_WIDTH  port 1 data
- s1_axis_tlast  in  1  port 1 end of packet
- s1_axis_tvalid  in  1  port 1 valid
- m_axis_tready  in  1  downstream ready
- m_axis_tdata  out  DATA_WIDTH  output data (registered)
- m_axis_tlast  out  1  output end of packet (registered)
- m_axis_tvalid  out  1  output valid (registered)
- m_axis_tid  out  1  source port of the current output beat
- busy  out  1  high when state is not IDLE
- trunc_err  out  1  sticky; set when a packet is truncated; cleared only by reset
- pkt_cnt0  out  CNT_WIDTH  packets completed from port 0; wraps
- pkt_cnt1  out  CNT_WIDTH  packets completed from port 1; wraps

Behaviour:
- Reset values: all outputs 0, state IDLE, rr_ptr = 0 (port 0 has priority), beat_cnt = 0.
- States: IDLE, PASS (grant g held), DRAIN (grant g held, input discarded).
- IDLE transitions (only when en = 1):
  - exactly one sX_axis_tvalid high -> grant that port;
  - both high -> grant port rr_ptr;
  - go to PASS.
  - The grant is registered, so the first beat is accepted on the cycle after the grant.
  - No sX_axis_tready is asserted in IDLE.
- PASS:
  - s_g tready = (!m_axis_tvalid || m_axis_tready); the other port's tready = 0.
  - Output register stage: one-cycle latency from input acceptance to m_axis_tvalid. Throughput is one beat per cycle while downstream is ready. The output register holds its contents while m_axis_tvalid && !m_axis_tready.
  - On each accepted beat: beat_cnt += 1; m_axis_tid = g.
  - Accepted beat has tlast = 1:
    - forward it with m_axis_tlast = 1;
    - increment pkt_cnt_g;
    - rr_ptr = ~g;
    - beat_cnt = 0;
    - go to IDLE.
    - This leaves one idle cycle between packets.
  - Accepted beat has tlast = 0, MAX_BEATS != 0 and beat_cnt + 1 == MAX_BEATS:
    - forward it with m_axis_tlast forced to 1;
    - set trunc_err;
    - go to DRAIN.
  - A tlast on the MAX_BEATS-th beat is a normal end; there is no truncation.
- DRAIN:
  - s_g tready = 1 and no beats are forwarded; m_axis_tvalid is unaffected by drained beats.
  - On the accepted tlast:
    - increment pkt_cnt_g;
    - rr_ptr = ~g;
    - beat_cnt = 0;
    - go to IDLE.
- en falling mid-packet has no effect until the packet ends; the block then stays in IDLE while en = 0.
- Single-beat packet (tlast on the first beat) is legal: it forwards one beat and returns to IDLE.
- Counters wrap modulo 2^CNT_WIDTH with no saturation. beat_cnt is a ceil(log2(MAX_BEATS + 1))-bit counter, minimum 1 bit.
- Reset asserted mid-packet:
  - all state clears immediately (asynchronously), including m_axis_tvalid;
  - the partial packet is lost;
  - after reset, arbitration restarts with port 0 priority.
- Input tdata/tlast sampling follows the AXIS rule: a beat transfers only on the cycle where tvalid && tready.

Decomposition:
- Shared package: state encoding constants (IDLE, PASS, DRAIN) and the port-ID constants (PORT0 = 0, PORT1 = 1).
- One natural sub-module, axis_reg_slice: a one-deep output register covering tdata/tlast/tid/valid and generating the ready-back term. The arbiter FSM, counters and truncation logic stay in the top level.

Test Plan:
- Port 0 sends a 4-beat packet (data 0x10..0x13) with m_axis_tready = 1 -> 4 output beats with m_axis_tid = 0, tlast on 0x13, pkt_cnt0 = 1, busy returns low.
- Both ports send 2-beat packets continuously -> output packet order 0,1,0,1; no beats interleave within a packet; exactly one idle cycle between packets.
- MAX_BEATS = 4; port 1 sends a 7-beat packet -> 4 beats output with tlast on the 4th, beats 5-7 drained with s1_axis_tready = 1, trunc_err = 1, pkt_cnt1 = 1.
- Port 0 sends an 8-beat packet while m_axis_tready toggles 1010… -> 8 beats output in order; m_axis_tdata and m_axis_tlast are stable whenever tvalid && !tready; no beat is lost or duplicated.
- en = 0 with both ports valid -> no tready for 10 cycles. Then en = 1 -> port 0 granted. Drop en on the 2nd beat -> the packet completes, then the block stays IDLE.
- Reset pulsed mid-packet of port 1 -> outputs go to 0 asynchronously. After release, both ports valid -> port 0 is granted first.
